// File: rtl/mvu_mac_kernel_gen2.sv
// PE x SIMD dot-product kernel with per-PE accumulation over last-delimited beats,
// optional saturation to OUT_WIDTH and a credit-managed in-order result FIFO.
module mvu_mac_kernel_gen2 #(
    parameter int unsigned PE                 = 4,
    parameter int unsigned SIMD               = 8,
    parameter int unsigned ACTIVATION_WIDTH   = 8,
    parameter int unsigned WEIGHT_WIDTH       = 8,
    parameter int unsigned ACCU_WIDTH         = 24,
    parameter int unsigned OUT_WIDTH          = 16,
    parameter bit          SIGNED_ACTIVATIONS = 1'b0,
    parameter bit          SIGNED_WEIGHTS     = 1'b1,
    parameter bit          SATURATE           = 1'b1,
    parameter int unsigned OUT_FIFO_DEPTH     = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 in_vld,
    output logic                                 in_rdy,
    input  logic                                 last,
    input  logic                                 zero,
    input  logic [PE*SIMD*WEIGHT_WIDTH-1:0]      w,
    input  logic [SIMD*ACTIVATION_WIDTH-1:0]     a,
    output logic                                 out_vld,
    input  logic                                 out_rdy,
    output logic [PE*OUT_WIDTH-1:0]              p,
    output logic [PE-1:0]                        sat,
    input  logic                                 sat_clr
);

    localparam int unsigned AW    = ACTIVATION_WIDTH;
    localparam int unsigned WW    = WEIGHT_WIDTH;
    localparam int unsigned PW    = AW + WW + 1;
    localparam int unsigned PTR_W = $clog2(OUT_FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic signed [ACCU_WIDTH-1:0] OUT_MAX =
        {{(ACCU_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACCU_WIDTH-1:0] OUT_MIN =
        {{(ACCU_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    logic                           s1_vld_q, s1_last_q, s1_zero_q;
    logic [SIMD*AW-1:0]             s1_a_q;
    logic [PE*SIMD*WW-1:0]          s1_w_q;
    logic                           s2_vld_q, s2_last_q;
    logic signed [PW-1:0]           s2_prod_q [PE][SIMD];
    logic signed [PW-1:0]           s2_prod_d [PE][SIMD];
    logic                           s3_vld_q, s3_last_q;
    logic signed [ACCU_WIDTH-1:0]   s3_sum_q [PE];
    logic signed [ACCU_WIDTH-1:0]   s3_sum_d [PE];
    logic                           s4_vld_q, s4_last_q;
    logic signed [ACCU_WIDTH-1:0]   acc_q [PE];
    logic                           first_q;

    logic [PE*OUT_WIDTH-1:0]        fifo_mem [OUT_FIFO_DEPTH];
    logic [PTR_W-1:0]               wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]               count_q;
    logic [CNT_W:0]                 outstanding;
    logic [PE*OUT_WIDTH-1:0]        conv;
    logic [PE-1:0]                  sat_set;
    logic [PE-1:0]                  sat_q;
    logic                           accept, push, pop;

    assign accept  = in_vld && in_rdy;
    assign push    = s4_vld_q && s4_last_q;
    assign out_vld = (count_q != '0);
    assign pop     = out_vld && out_rdy;
    assign p       = out_vld ? fifo_mem[rd_ptr_q] : '0;
    assign sat     = sat_q;

    // Every last beat in flight already owns a FIFO slot, so the FIFO cannot overflow.
    assign outstanding = {1'b0, count_q}
                       + {{CNT_W{1'b0}}, s1_vld_q & s1_last_q}
                       + {{CNT_W{1'b0}}, s2_vld_q & s2_last_q}
                       + {{CNT_W{1'b0}}, s3_vld_q & s3_last_q}
                       + {{CNT_W{1'b0}}, s4_vld_q & s4_last_q};
    assign in_rdy = (outstanding < (CNT_W+1)'(OUT_FIFO_DEPTH));

    always_comb begin
        logic signed [PW-1:0] a_ext;
        logic signed [PW-1:0] w_ext;
        for (int k = 0; k < PE; k++) begin
            for (int s = 0; s < SIMD; s++) begin
                a_ext = SIGNED_ACTIVATIONS
                      ? {{(PW-AW){s1_a_q[s*AW+AW-1]}}, s1_a_q[s*AW +: AW]}
                      : {{(PW-AW){1'b0}}, s1_a_q[s*AW +: AW]};
                w_ext = SIGNED_WEIGHTS
                      ? {{(PW-WW){s1_w_q[(k*SIMD+s)*WW+WW-1]}}, s1_w_q[(k*SIMD+s)*WW +: WW]}
                      : {{(PW-WW){1'b0}}, s1_w_q[(k*SIMD+s)*WW +: WW]};
                s2_prod_d[k][s] = s1_zero_q ? '0 : a_ext * w_ext;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < PE; k++) begin
            s3_sum_d[k] = '0;
            for (int s = 0; s < SIMD; s++) begin
                s3_sum_d[k] = s3_sum_d[k]
                            + {{(ACCU_WIDTH-PW){s2_prod_q[k][s][PW-1]}}, s2_prod_q[k][s]};
            end
        end
    end

    always_comb begin
        conv    = '0;
        sat_set = '0;
        for (int k = 0; k < PE; k++) begin
            conv[k*OUT_WIDTH +: OUT_WIDTH] = acc_q[k][OUT_WIDTH-1:0];
            if (SATURATE && (acc_q[k] > OUT_MAX)) begin
                conv[k*OUT_WIDTH +: OUT_WIDTH] = {1'b0, {(OUT_WIDTH-1){1'b1}}};
                sat_set[k] = 1'b1;
            end else if (SATURATE && (acc_q[k] < OUT_MIN)) begin
                conv[k*OUT_WIDTH +: OUT_WIDTH] = {1'b1, {(OUT_WIDTH-1){1'b0}}};
                sat_set[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q  <= 1'b0;
            s1_last_q <= 1'b0;
            s1_zero_q <= 1'b0;
            s2_vld_q  <= 1'b0;
            s2_last_q <= 1'b0;
            s3_vld_q  <= 1'b0;
            s3_last_q <= 1'b0;
            s4_vld_q  <= 1'b0;
            s4_last_q <= 1'b0;
            first_q   <= 1'b1;
            for (int k = 0; k < PE; k++) acc_q[k] <= '0;
        end else begin
            s1_vld_q  <= accept;
            s1_last_q <= accept && last;
            s1_zero_q <= accept && zero;
            s2_vld_q  <= s1_vld_q;
            s2_last_q <= s1_last_q;
            s3_vld_q  <= s2_vld_q;
            s3_last_q <= s2_last_q;
            s4_vld_q  <= s3_vld_q;
            s4_last_q <= s3_last_q;
            if (s3_vld_q) begin
                first_q <= s3_last_q;
                for (int k = 0; k < PE; k++) begin
                    acc_q[k] <= (first_q ? '0 : acc_q[k]) + s3_sum_q[k];
                end
            end
        end
    end

    // Datapath registers are qualified by the stage valids and need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_a_q <= a;
            s1_w_q <= w;
        end
        s2_prod_q <= s2_prod_d;
        s3_sum_q  <= s3_sum_d;
        if (push) fifo_mem[wr_ptr_q] <= conv;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            sat_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
            if (sat_clr)   sat_q <= '0;
            else if (push) sat_q <= sat_q | sat_set;
        end
    end

`ifndef SYNTHESIS
    assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && (count_q == CNT_W'(OUT_FIFO_DEPTH))))
        else $fatal(1, "result fifo overflow");
`endif

endmodule

// File: tb/tb_mvu_mac_kernel_gen2.sv
// Randomised and directed bench for mvu_mac_kernel_gen2; two instances (saturating/unsigned
// activations and truncating/signed activations) share stimulus and a transaction-level model.
module tb_mvu_mac_kernel_gen2;

    localparam int PE   = 4;
    localparam int SIMD = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic in_vld, last, zero, out_rdy, sat_clr;
    logic [SIMD*8-1:0]    a;
    logic [PE*SIMD*8-1:0] w;
    logic in_rdy0, in_rdy1, out_vld0, out_vld1;
    logic [PE*16-1:0] p0, p1;
    logic [PE-1:0] sat0, sat1;

    always #5 clk = ~clk;

    mvu_mac_kernel_gen2 u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy0), .last(last),
        .zero(zero), .w(w), .a(a), .out_vld(out_vld0), .out_rdy(out_rdy), .p(p0),
        .sat(sat0), .sat_clr(sat_clr)
    );

    mvu_mac_kernel_gen2 #(.SIGNED_ACTIVATIONS(1'b1), .SATURATE(1'b0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy1), .last(last),
        .zero(zero), .w(w), .a(a), .out_vld(out_vld1), .out_rdy(out_rdy), .p(p1),
        .sat(sat1), .sat_clr(sat_clr)
    );

    typedef struct {
        logic [63:0] r0;
        logic [63:0] r1;
        logic [3:0]  s0;
        int          avail;
    } res_t;

    res_t       q[$];
    longint     acc0[PE];
    longint     acc1[PE];
    bit         first;
    logic [3:0] sat_exp;
    int         cyc;
    int         total;
    int         bad;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic longint wrap_acc(input longint x);
        longint y;
        y = x & 64'hFF_FFFF;
        if (y >= 64'h80_0000) y = y - 64'h100_0000;
        return y;
    endfunction

    function automatic logic [15:0] to_out(input longint v, input bit satur, output bit s);
        s = 1'b0;
        if (satur && v > 32767) begin
            s = 1'b1;
            return 16'h7FFF;
        end
        if (satur && v < -32768) begin
            s = 1'b1;
            return 16'h8000;
        end
        return v[15:0];
    endfunction

    function automatic int elem_a(input int s, input bit sgn);
        logic [7:0] e;
        e = a[s*8 +: 8];
        return (sgn && e[7]) ? int'(e) - 256 : int'(e);
    endfunction

    function automatic int elem_w(input int k, input int s);
        logic [7:0] e;
        e = w[(k*SIMD+s)*8 +: 8];
        return e[7] ? int'(e) - 256 : int'(e);
    endfunction

    function automatic logic [63:0] mk_a(input int v);
        logic [63:0] r;
        for (int s = 0; s < SIMD; s++) r[s*8 +: 8] = v[7:0];
        return r;
    endfunction

    function automatic logic [255:0] mk_w(input int base, input int inc);
        logic [255:0] r;
        int x;
        for (int k = 0; k < PE; k++) begin
            x = base + inc * k;
            for (int s = 0; s < SIMD; s++) r[(k*SIMD+s)*8 +: 8] = x[7:0];
        end
        return r;
    endfunction

    // Advance the model across the coming rising edge using the inputs now applied.
    task automatic model_edge();
        bit rdy, hv, sb;
        logic [3:0] sn;
        longint c0, c1;
        res_t r;
        rdy = q.size() < 4;
        hv  = q.size() > 0 && q[0].avail <= cyc;
        sn  = sat_exp;
        foreach (q[i]) if (q[i].avail == cyc + 1) sn = sn | q[i].s0;
        sat_exp = sat_clr ? 4'b0 : sn;
        if (hv && out_rdy) void'(q.pop_front());
        if (in_vld && rdy) begin
            for (int k = 0; k < PE; k++) begin
                c0 = 0;
                c1 = 0;
                if (!zero) begin
                    for (int s = 0; s < SIMD; s++) begin
                        c0 += longint'(elem_a(s, 1'b0) * elem_w(k, s));
                        c1 += longint'(elem_a(s, 1'b1) * elem_w(k, s));
                    end
                end
                acc0[k] = wrap_acc((first ? 0 : acc0[k]) + c0);
                acc1[k] = wrap_acc((first ? 0 : acc1[k]) + c1);
            end
            first = last;
            if (last) begin
                for (int k = 0; k < PE; k++) begin
                    r.r0[k*16 +: 16] = to_out(acc0[k], 1'b1, sb);
                    r.s0[k]          = sb;
                    r.r1[k*16 +: 16] = to_out(acc1[k], 1'b0, sb);
                end
                r.avail = cyc + 5;
                q.push_back(r);
            end
        end
    endtask

    task automatic model_reset();
        q.delete();
        first   = 1'b1;
        sat_exp = '0;
        for (int k = 0; k < PE; k++) begin
            acc0[k] = 0;
            acc1[k] = 0;
        end
    endtask

    task automatic check_outputs();
        bit ev;
        ev = q.size() > 0 && q[0].avail <= cyc;
        check("in_rdy0", in_rdy0, q.size() < 4);
        check("in_rdy1", in_rdy1, q.size() < 4);
        check("out_vld0", out_vld0, ev);
        check("out_vld1", out_vld1, ev);
        if (ev) begin
            check("p0", p0, q[0].r0);
            check("p1", p1, q[0].r1);
        end
        check("sat0", sat0, sat_exp);
        check("sat1", sat1, 4'b0);
    endtask

    task automatic step();
        model_edge();
        @(negedge clk);
        cyc++;
        check_outputs();
    endtask

    task automatic beat(input bit v, input bit l, input bit z, input logic [63:0] av,
                        input logic [255:0] wv);
        in_vld = v;
        last   = l;
        zero   = z;
        a      = av;
        w      = wv;
        step();
    endtask

    task automatic idle(input int n);
        in_vld = 1'b0;
        last   = 1'b0;
        zero   = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_out_vld", out_vld0, 1'b0);
        check("rst_in_rdy", in_rdy0, 1'b1);
        check("rst_p", p0, 64'h0);
        check("rst_sat", sat0, 4'b0);
        model_reset();
        @(negedge clk);
        cyc++;
        rst_n = 1'b1;
    endtask

    initial begin
        int k;
        total   = 0;
        bad     = 0;
        cyc     = 0;
        rst_n   = 1'b0;
        in_vld  = 1'b0;
        last    = 1'b0;
        zero    = 1'b0;
        out_rdy = 1'b1;
        sat_clr = 1'b0;
        a       = '0;
        w       = '0;
        model_reset();
        @(negedge clk);
        do_reset();
        check_outputs();

        // Single beat: 8 * 3 * -2 = -48 on every PE.
        beat(1, 1, 0, mk_a(3), mk_w(-2, 0));
        idle(7);

        // Three beats with gaps; p[k] = 24*(k+1).
        beat(1, 0, 0, mk_a(1), mk_w(1, 1));
        idle(2);
        beat(1, 0, 0, mk_a(1), mk_w(1, 1));
        idle(2);
        beat(1, 1, 0, mk_a(1), mk_w(1, 1));
        idle(7);

        // Saturation high, clear, saturation low.
        beat(1, 1, 0, mk_a(255), mk_w(127, 0));
        idle(7);
        sat_clr = 1'b1;
        step();
        sat_clr = 1'b0;
        beat(1, 1, 0, mk_a(255), mk_w(-128, 0));
        idle(7);

        // Backpressure: six last beats against a stalled output.
        out_rdy = 1'b0;
        k = 0;
        for (int i = 0; i < 40; i++) begin
            if (i == 12) out_rdy = 1'b1;
            in_vld = (k < 6);
            last   = 1'b1;
            zero   = 1'b0;
            a      = mk_a(k + 1);
            w      = mk_w(1, 0);
            if (in_vld && q.size() < 4) k++;
            step();
        end
        idle(4);

        // Zero-tagged middle beat, and a=-1 / w=-1 for the signed-activation instance.
        beat(1, 0, 0, mk_a(2), mk_w(3, 0));
        beat(1, 0, 1, mk_a(9), mk_w(9, 0));
        beat(1, 1, 0, mk_a(1), mk_w(1, 0));
        beat(1, 1, 0, mk_a(255), mk_w(-1, 0));
        idle(7);

        // Reset with two results queued and a beat in flight.
        out_rdy = 1'b0;
        beat(1, 1, 0, mk_a(2), mk_w(1, 0));
        beat(1, 1, 0, mk_a(4), mk_w(1, 0));
        idle(6);
        beat(1, 0, 0, mk_a(5), mk_w(5, 0));
        idle(1);
        do_reset();
        out_rdy = 1'b1;
        check_outputs();
        beat(1, 1, 0, mk_a(1), mk_w(1, 0));
        idle(7);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            in_vld  = ($urandom_range(0, 3) != 0);
            last    = ($urandom_range(0, 2) == 0);
            zero    = ($urandom_range(0, 7) == 0);
            out_rdy = ($urandom_range(0, 3) != 0);
            sat_clr = ($urandom_range(0, 15) == 0);
            for (int s = 0; s < SIMD; s++) a[s*8 +: 8] = 8'($urandom);
            for (int j = 0; j < PE * SIMD; j++) w[j*8 +: 8] = 8'($urandom);
            step();
        end
        sat_clr = 1'b0;
        out_rdy = 1'b1;
        idle(12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
